// File: rtl/multi_scorekeeper.sv
// multi_scorekeeper: N-player score tracker for the game top level.
// Counts one point per rising edge of the award strobe for every flagged
// player, saturates each counter, tracks a registered unique leader and
// latches the match result when a player reaches the target score.
module multi_scorekeeper #(
  parameter  int NUM_PLAYERS = 4,
  parameter  int SCORE_W     = 8,
  parameter  int WIN_SCORE   = 10,
  localparam int IDX_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           new_match_i,
  input  logic [NUM_PLAYERS-1:0]         win_vec_i,
  input  logic                           add_i,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores_o,
  output logic                           award_ack_o,
  output logic [IDX_W-1:0]               leader_o,
  output logic                           leader_valid_o,
  output logic                           match_over_o,
  output logic [IDX_W-1:0]               winner_o,
  output logic                           multi_win_o
);

  typedef enum logic {ST_PLAYING = 1'b0, ST_OVER = 1'b1} state_e;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  // A player reaches the target when it is one below it and gets awarded.
  localparam logic [SCORE_W-1:0] WIN_M1    = SCORE_W'(WIN_SCORE - 1);

  state_e                 state_q, state_d;
  logic                   add_q;
  logic                   add_rise;
  logic                   clear_w;
  logic                   award_go;
  logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]     score_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] reach_w;
  logic                   ack_q;
  logic [IDX_W-1:0]       leader_q;
  logic                   leader_valid_q;
  logic [IDX_W-1:0]       winner_q, winner_d;
  logic                   multi_win_q, multi_win_d;
  logic [SCORE_W-1:0]     lead_max;
  logic [IDX_W-1:0]       lead_idx;
  logic                   lead_unique;

  // Reset and new_match share the clear path; only Reset touches add_q.
  assign clear_w  = reset_i | new_match_i;
  assign add_rise = add_i & ~add_q;

  // Strobe history for rising-edge qualification of add.
  always_ff @(posedge clk_i) begin
    if (reset_i) add_q <= 1'b0;
    else         add_q <= add_i;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (clear_w) state_q <= ST_PLAYING;
    else         state_q <= state_d;
  end

  // Next state: the award that lands any player on the target ends the match.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_PLAYING && (|reach_w)) state_d = ST_OVER;
  end

  // FSM outputs: award enable and the result of the ending award.
  always_comb begin
    award_go    = (state_q == ST_PLAYING) & add_rise & (|win_vec_i);
    winner_d    = '0;
    multi_win_d = ($countones(reach_w) > 1);
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (reach_w[i]) winner_d = IDX_W'(i);
    end
  end

  // Per-player flags and packed score output.
  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
    assign reach_w[gi] = award_go & win_vec_i[gi] & (score_q[gi] == WIN_M1);
    assign scores_o[gi*SCORE_W +: SCORE_W] = score_q[gi];
  end

  // Score next-state: +1 for flagged players, holding at full scale.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      score_d[i] = score_q[i];
      if (award_go && win_vec_i[i] && score_q[i] != SCORE_MAX)
        score_d[i] = score_q[i] + 1'b1;
    end
  end

  // Score registers.
  always_ff @(posedge clk_i) begin
    if (clear_w) begin
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  // Ack pulse and match result latch.
  always_ff @(posedge clk_i) begin
    if (clear_w) begin
      ack_q       <= 1'b0;
      winner_q    <= '0;
      multi_win_q <= 1'b0;
    end else begin
      ack_q <= award_go;
      if (state_q == ST_PLAYING && (|reach_w)) begin
        winner_q    <= winner_d;
        multi_win_q <= multi_win_d;
      end
    end
  end

  // Unique maximum search over the registered scores; any tie at the top
  // (including all-zero) clears lead_unique.
  always_comb begin
    lead_max    = '0;
    lead_idx    = '0;
    lead_unique = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (score_q[i] > lead_max) begin
        lead_max    = score_q[i];
        lead_idx    = IDX_W'(i);
        lead_unique = 1'b1;
      end else if (score_q[i] == lead_max) begin
        lead_unique = 1'b0;
      end
    end
  end

  // Leader register: keeps the previous index while there is no unique leader.
  always_ff @(posedge clk_i) begin
    if (clear_w) begin
      leader_q       <= '0;
      leader_valid_q <= 1'b0;
    end else begin
      leader_valid_q <= lead_unique;
      if (lead_unique) leader_q <= lead_idx;
    end
  end

  assign award_ack_o    = ack_q;
  assign leader_o       = leader_q;
  assign leader_valid_o = leader_valid_q;
  assign match_over_o   = (state_q == ST_OVER);
  assign winner_o       = winner_q;
  assign multi_win_o    = multi_win_q;

endmodule

// File: tb/tb_multi_scorekeeper.sv
// Testbench for multi_scorekeeper: table of stimulus phases with expected end
// state, a per-cycle reference model feeding a scoreboard queue, and a short
// hand-written sequence on a narrow-score instance.
module tb_multi_scorekeeper;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: 4 players, 8-bit scores, target 10.
  logic        rst, nm, add;
  logic [3:0]  win;
  logic [31:0] scores;
  logic        award_ack, leader_valid, match_over, multi_win;
  logic [1:0]  leader, winner;

  multi_scorekeeper dut (
    .clk_i(clk), .reset_i(rst), .new_match_i(nm), .win_vec_i(win), .add_i(add),
    .scores_o(scores), .award_ack_o(award_ack), .leader_o(leader),
    .leader_valid_o(leader_valid), .match_over_o(match_over),
    .winner_o(winner), .multi_win_o(multi_win)
  );

  // Narrow instance: 3-bit scores, target 7.
  logic        s_rst, s_nm, s_add;
  logic [3:0]  s_win;
  logic [11:0] s_scores;
  logic        s_ack, s_lv, s_over, s_multi;
  logic [1:0]  s_leader, s_winner;

  multi_scorekeeper #(.NUM_PLAYERS(4), .SCORE_W(3), .WIN_SCORE(7)) dut_s (
    .clk_i(clk), .reset_i(s_rst), .new_match_i(s_nm), .win_vec_i(s_win), .add_i(s_add),
    .scores_o(s_scores), .award_ack_o(s_ack), .leader_o(s_leader),
    .leader_valid_o(s_lv), .match_over_o(s_over),
    .winner_o(s_winner), .multi_win_o(s_multi)
  );

  int checks = 0;
  int errors = 0;
  int ack_cnt;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [31:0] sc;
    logic        ack;
    logic [1:0]  leader;
    logic        lv;
    logic        over;
    logic [1:0]  winner;
    logic        multi;
  } exp_t;

  exp_t sb_q[$];

  int m_sc[4];
  bit m_addq, m_ack, m_lv, m_over, m_multi;
  int m_lead, m_winner;

  task automatic model_step(bit r, bit n, bit a, logic [3:0] w);
    int mx, cnt, idx, nreach;
    bit go;
    if (r || n) begin
      for (int i = 0; i < 4; i++) m_sc[i] = 0;
      m_ack = 0; m_lv = 0; m_over = 0; m_multi = 0; m_lead = 0; m_winner = 0;
      m_addq = r ? 1'b0 : a;
    end else begin
      // leader judged on the scores as they stood before this edge
      mx = 0; cnt = 0; idx = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_sc[i] > mx) begin mx = m_sc[i]; idx = i; cnt = 1; end
        else if (m_sc[i] == mx) cnt++;
      end
      if (mx > 0 && cnt == 1) begin m_lead = idx; m_lv = 1; end
      else m_lv = 0;
      go = !m_over && a && !m_addq && (w != 4'b0);
      m_addq = a;
      m_ack = go;
      if (go) begin
        nreach = 0;
        for (int i = 0; i < 4; i++) begin
          if (w[i]) begin
            if (m_sc[i] < 255) begin
              m_sc[i]++;
              if (m_sc[i] == 10) begin
                if (nreach == 0) m_winner = i;
                nreach++;
              end
            end
          end
        end
        if (nreach > 0) begin m_over = 1; m_multi = (nreach > 1); end
      end
    end
  endtask

  task automatic cycle(bit r, bit n, bit a, logic [3:0] w);
    exp_t e, g;
    int   tmp;
    rst = r; nm = n; add = a; win = w;
    @(posedge clk);
    model_step(r, n, a, w);
    e = '0;
    for (int i = 0; i < 4; i++) begin
      tmp = m_sc[i];
      e.sc[i*8 +: 8] = tmp[7:0];
    end
    tmp = m_lead;   e.leader = tmp[1:0];
    tmp = m_winner; e.winner = tmp[1:0];
    e.ack = m_ack; e.lv = m_lv; e.over = m_over; e.multi = m_multi;
    sb_q.push_back(e);
    @(negedge clk);
    g = sb_q.pop_front();
    chk("cyc_scores", scores, g.sc);
    chk("cyc_ack", 32'(award_ack), 32'(g.ack));
    chk("cyc_leader", 32'(leader), 32'(g.leader));
    chk("cyc_leader_valid", 32'(leader_valid), 32'(g.lv));
    chk("cyc_match_over", 32'(match_over), 32'(g.over));
    chk("cyc_winner", 32'(winner), 32'(g.winner));
    chk("cyc_multi_win", 32'(multi_win), 32'(g.multi));
    if (award_ack === 1'b1) ack_cnt++;
  endtask

  // ---------------- phase table ----------------
  typedef struct {
    bit          rst;
    bit          nm;
    bit          pulse;   // 1: n x (low,high) pulses; 0: add held at lvl n cycles
    bit          lvl;
    logic [3:0]  win;
    int          n;
    int          settle;  // extra cycles, add kept, win=0
    logic [31:0] sc;
    int          acks;
    bit          over;
    int          winner;
    bit          multi;
    int          leader;
    bit          lv;
  } row_t;

  localparam int NROWS = 19;
  row_t rows[NROWS];

  task automatic s_cycle(bit r, bit n, bit a, logic [3:0] w);
    s_rst = r; s_nm = n; s_add = a; s_win = w;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //               rst   nm    pulse lvl   win      n  st sc            ack over  w  multi L  lv
    rows[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2,  0, 32'h0000_0000, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    rows[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 20, 2, 32'h0000_0100, 1, 1'b0, 0, 1'b0, 1, 1'b1};
    rows[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1,  0, 32'h0000_0000, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    rows[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 3,  2, 32'h0003_0003, 3, 1'b0, 0, 1'b0, 0, 1'b0};
    rows[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1,  0, 32'h0000_0000, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    rows[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 10, 2, 32'h0A00_0000, 10, 1'b1, 3, 1'b0, 3, 1'b1};
    rows[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 1,  2, 32'h0A00_0000, 0, 1'b1, 3, 1'b0, 3, 1'b1};
    rows[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1,  0, 32'h0000_0000, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    rows[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 9,  2, 32'h0009_0009, 9, 1'b0, 0, 1'b0, 0, 1'b0};
    rows[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 1,  2, 32'h000A_000A, 1, 1'b1, 0, 1'b1, 0, 1'b0};
    rows[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1,  0, 32'h000A_000A, 0, 1'b1, 0, 1'b1, 0, 1'b0};
    // Reset on the same cycle as an add rising edge: nothing scores.
    rows[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1,  0, 32'h0000_0000, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    // Reset cleared the strobe history, so the still-high add is a fresh edge.
    rows[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 4,  2, 32'h0000_0001, 1, 1'b0, 0, 1'b0, 0, 1'b1};
    // new_match keeps the strobe history: held add must fall and rise again.
    rows[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 1,  0, 32'h0000_0000, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    rows[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 5,  2, 32'h0000_0000, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    rows[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1,  2, 32'h0000_0001, 1, 1'b0, 0, 1'b0, 0, 1'b1};
    rows[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0110, 2,  2, 32'h0002_0201, 2, 1'b0, 0, 1'b0, 0, 1'b0};
    rows[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 1,  2, 32'h0003_0201, 1, 1'b0, 0, 1'b0, 2, 1'b1};
    rows[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 1,  2, 32'h0003_0301, 1, 1'b0, 0, 1'b0, 2, 1'b0};

    rst = 1'b1; nm = 1'b0; add = 1'b0; win = 4'b0;
    s_rst = 1'b1; s_nm = 1'b0; s_add = 1'b0; s_win = 4'b0;
    for (int i = 0; i < 4; i++) m_sc[i] = 0;
    m_addq = 0; m_ack = 0; m_lv = 0; m_over = 0; m_multi = 0; m_lead = 0; m_winner = 0;
    @(negedge clk);

    for (int r = 0; r < NROWS; r++) begin
      ack_cnt = 0;
      for (int k = 0; k < rows[r].n; k++) begin
        if (rows[r].pulse) begin
          cycle(rows[r].rst, rows[r].nm, 1'b0, rows[r].win);
          cycle(rows[r].rst, rows[r].nm, 1'b1, rows[r].win);
        end else begin
          cycle(rows[r].rst, rows[r].nm, rows[r].lvl, rows[r].win);
        end
      end
      for (int k = 0; k < rows[r].settle; k++) cycle(1'b0, 1'b0, add, 4'b0000);
      chk($sformatf("row%0d_scores", r), scores, rows[r].sc);
      chk($sformatf("row%0d_acks", r), 32'(ack_cnt), 32'(rows[r].acks));
      chk($sformatf("row%0d_match_over", r), 32'(match_over), 32'(rows[r].over));
      chk($sformatf("row%0d_winner", r), 32'(winner), 32'(rows[r].winner));
      chk($sformatf("row%0d_multi_win", r), 32'(multi_win), 32'(rows[r].multi));
      chk($sformatf("row%0d_leader", r), 32'(leader), 32'(rows[r].leader));
      chk($sformatf("row%0d_leader_valid", r), 32'(leader_valid), 32'(rows[r].lv));
      $display("row %0d: scores=%h acks=%0d over=%0b winner=%0d multi=%0b leader=%0d lv=%0b",
               r, scores, ack_cnt, match_over, winner, multi_win, leader, leader_valid);
    end
    rst = 1'b1;

    // ---------------- narrow instance: SCORE_W=3, WIN_SCORE=7 ----------------
    s_cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    chk("s_reset_scores", 32'(s_scores), 32'h0);
    chk("s_reset_ack", 32'(s_ack), 32'h0);
    chk("s_reset_over", 32'(s_over), 32'h0);
    for (int k = 0; k < 8; k++) begin
      s_cycle(1'b0, 1'b0, 1'b0, 4'b0000);
      s_cycle(1'b0, 1'b0, 1'b1, 4'b0000);
      chk($sformatf("s_nowin_ack%0d", k), 32'(s_ack), 32'h0);
    end
    chk("s_nowin_scores", 32'(s_scores), 32'h0);
    chk("s_nowin_over", 32'(s_over), 32'h0);
    $display("narrow: 8 empty pulses scores=%h", s_scores);

    for (int k = 0; k < 3; k++) begin
      s_cycle(1'b0, 1'b0, 1'b0, 4'b0010);
      s_cycle(1'b0, 1'b0, 1'b1, 4'b0010);
    end
    s_cycle(1'b0, 1'b0, 1'b1, 4'b0000);
    s_cycle(1'b0, 1'b0, 1'b1, 4'b0000);
    chk("s_mid_scores", 32'(s_scores), 32'h018);
    chk("s_mid_leader", 32'(s_leader), 32'h1);
    chk("s_mid_leader_valid", 32'(s_lv), 32'h1);
    $display("narrow: mid-match scores=%h leader=%0d", s_scores, s_leader);

    s_cycle(1'b0, 1'b1, 1'b1, 4'b0000);
    chk("s_nm_scores", 32'(s_scores), 32'h0);
    chk("s_nm_ack", 32'(s_ack), 32'h0);
    chk("s_nm_leader", 32'(s_leader), 32'h0);
    chk("s_nm_leader_valid", 32'(s_lv), 32'h0);
    chk("s_nm_over", 32'(s_over), 32'h0);
    chk("s_nm_winner", 32'(s_winner), 32'h0);
    chk("s_nm_multi", 32'(s_multi), 32'h0);
    $display("narrow: after new_match scores=%h", s_scores);

    for (int k = 0; k < 7; k++) begin
      s_cycle(1'b0, 1'b0, 1'b0, 4'b0010);
      s_cycle(1'b0, 1'b0, 1'b1, 4'b0010);
    end
    chk("s_end_ack", 32'(s_ack), 32'h1);
    chk("s_end_scores", 32'(s_scores), 32'h038);
    chk("s_end_over", 32'(s_over), 32'h1);
    chk("s_end_winner", 32'(s_winner), 32'h1);
    chk("s_end_multi", 32'(s_multi), 32'h0);
    s_cycle(1'b0, 1'b0, 1'b0, 4'b0010);
    s_cycle(1'b0, 1'b0, 1'b1, 4'b0010);
    chk("s_frozen_ack", 32'(s_ack), 32'h0);
    chk("s_frozen_scores", 32'(s_scores), 32'h038);
    $display("narrow: match over scores=%h winner=%0d", s_scores, s_winner);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
